// File: rtl/booth_mult_ctrl_pkg.sv
// Shared definitions for the radix-2 Booth multiplier controller:
// FSM state encoding, iteration count and Booth selector codes.
package booth_mult_ctrl_pkg;

    localparam int unsigned IterCount = 32;
    localparam int unsigned CntWidth  = $clog2(IterCount);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // Indexed by {Q[0], q_1}
    typedef enum logic [1:0] {
        SelNone = 2'b00,
        SelAdd  = 2'b01,
        SelSub  = 2'b10,
        SelHold = 2'b11
    } booth_sel_e;

endpackage

// File: rtl/booth_select.sv
// Booth recoding step: maps {Q[0], q_1} and multiplicand M onto the second
// adder operand and carry-in (add M, subtract M as ~M + 1, or add nothing).
module booth_select
    import booth_mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] y,
    output logic             cin
);

    always_comb begin
        y   = '0;
        cin = 1'b0;
        unique case (booth_sel_e'(sel))
            SelAdd: y = m;
            SelSub: begin
                y   = ~m;
                cin = 1'b1;
            end
            SelNone, SelHold: ;
        endcase
    end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Radix-2 Booth multiplier controller driving an external carry-lookahead adder.
// Define MULT_OVF_DETECT_EN to enable the signed-overflow flag on data_exception.
module booth_mult_ctrl
    import booth_mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    output logic             add_cin,
    output logic [WIDTH-1:0] add_p,
    output logic [WIDTH-1:0] add_g,
    input  logic [WIDTH-1:0] add_s,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    state_e state_q, state_d;

    logic [WIDTH-1:0]    a_q, q_q, m_q;
    logic                q1_q;
    logic [CntWidth-1:0] cnt_q;

    logic [WIDTH-1:0] a_d, q_d;
    logic             q1_d;
    logic [WIDTH-1:0] sel_y;
    logic             sel_cin;
    logic             ovf, msb;
    logic             step, last;
    logic [WIDTH-1:0] result_q;

    booth_select #(
        .WIDTH (WIDTH)
    ) u_booth_select (
        .sel (({q_q[0], q1_q})),
        .m   (m_q),
        .y   (sel_y),
        .cin (sel_cin)
    );

    assign step = (state_q == StRun) && !ctrl_MULT;
    assign last = (cnt_q == CntWidth'(IterCount - 1));

    // The adder result may overflow 32 bits; recover the true sign for the shift.
    assign ovf  = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (add_s[WIDTH-1] != add_x[WIDTH-1]);
    assign msb  = add_s[WIDTH-1] ^ ovf;
    assign a_d  = {msb, add_s[WIDTH-1:1]};
    assign q_d  = {add_s[0], q_q[WIDTH-1:1]};
    assign q1_d = q_q[0];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start pulse in any state (re)starts the operation
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = ctrl_MULT ? StRun : StIdle;
            StRun:   state_d = ctrl_MULT ? StRun : (last ? StDone : StRun);
            StDone:  state_d = ctrl_MULT ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        add_x          = '0;
        add_y          = '0;
        add_cin        = 1'b0;
        data_resultRDY = 1'b0;
        unique case (state_q)
            StRun: begin
                add_x   = a_q;
                add_y   = sel_y;
                add_cin = sel_cin;
            end
            StDone:  data_resultRDY = 1'b1;
            default: ;
        endcase
        add_p = add_x | add_y;
        add_g = add_x & add_y;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q   <= '0;
            q_q   <= '0;
            q1_q  <= 1'b0;
            m_q   <= '0;
            cnt_q <= '0;
        end else if (ctrl_MULT) begin
            a_q   <= '0;
            q_q   <= data_operandB;
            q1_q  <= 1'b0;
            m_q   <= data_operandA;
            cnt_q <= '0;
        end else if (step) begin
            a_q   <= a_d;
            q_q   <= q_d;
            q1_q  <= q1_d;
            cnt_q <= cnt_q + CntWidth'(1);
        end
    end

    // Capture the final product on the edge entering DONE so it is valid with the pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            result_q <= '0;
        end else if (step && last) begin
            result_q <= q_d;
        end
    end

    assign data_result = result_q;

`ifdef MULT_OVF_DETECT_EN
    logic exc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            exc_q <= 1'b0;
        end else if (step && last) begin
            exc_q <= (a_d != {WIDTH{q_d[WIDTH-1]}});
        end
    end

    assign data_exception = exc_q;
`else
    assign data_exception = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed self-checking bench for booth_mult_ctrl with a behavioural adder.
module tb_booth_mult_ctrl;

`ifdef MULT_OVF_DETECT_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] opa, opb;
    logic        ctrl;
    logic [31:0] add_x, add_y, add_p, add_g, add_s;
    logic        add_cin;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int errors = 0;
    int checks = 0;

    booth_mult_ctrl #(
        .WIDTH (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .ctrl_MULT      (ctrl),
        .add_x          (add_x),
        .add_y          (add_y),
        .add_cin        (add_cin),
        .add_p          (add_p),
        .add_g          (add_g),
        .add_s          (add_s),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    assign add_s = add_x + add_y + {31'b0, add_cin};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Start an operation, then run ncyc cycles; in cycle ev_cyc either reset
    // (ev_rst) or re-pulse ctrl_MULT with a2/b2. Records RDY pulses.
    task automatic drive_window(input logic [31:0] a, input logic [31:0] b,
                                input int ev_cyc, input logic ev_rst,
                                input logic [31:0] a2, input logic [31:0] b2,
                                input int ncyc, output int n_rdy, output int first_rdy,
                                output int last_rdy, output logic [31:0] first_res,
                                output logic first_exc);
        @(negedge clock);
        opa = a; opb = b; ctrl = 1'b1; reset = 1'b0;
        n_rdy = 0; first_rdy = -1; last_rdy = -1;
        first_res = '0; first_exc = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clock);
            ctrl  = 1'b0;
            reset = 1'b0;
            if (data_resultRDY === 1'b1) begin
                n_rdy++;
                if (first_rdy < 0) begin
                    first_rdy = k;
                    first_res = data_result;
                    first_exc = data_exception;
                end
                last_rdy = k;
            end
            if (k == ev_cyc) begin
                if (ev_rst) reset = 1'b1;
                else begin
                    opa = a2; opb = b2; ctrl = 1'b1;
                end
            end
        end
        ctrl  = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ctrl = 1'b1; opa = 32'h1234; opb = 32'h5678;
        repeat (3) @(negedge clock);
        checks++;
        if (data_resultRDY !== 1'b0 || data_result !== 32'h0 || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b res=%h exc=%b want 0/0/0",
                     data_resultRDY, data_result, data_exception);
        end
        checks++;
        if (add_x !== 0 || add_y !== 0 || add_cin !== 0 || add_p !== 0 || add_g !== 0) begin
            errors++;
            $display("FAIL reset_adder: x=%h y=%h cin=%b p=%h g=%h want all 0",
                     add_x, add_y, add_cin, add_p, add_g);
        end
        reset = 1'b0; ctrl = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_adder_drive();
        @(negedge clock);
        opa = 32'd3; opb = 32'd5; ctrl = 1'b1;
        @(negedge clock);
        ctrl = 1'b0;
        // Cycle 1: {Q0,q1}=10 -> subtract 3
        checks++;
        if (add_x !== 32'h0 || add_y !== 32'hFFFFFFFC || add_cin !== 1'b1 ||
            add_p !== 32'hFFFFFFFC || add_g !== 32'h0) begin
            errors++;
            $display("FAIL run_cycle1: x=%h y=%h cin=%b p=%h g=%h want 0/fffffffc/1/fffffffc/0",
                     add_x, add_y, add_cin, add_p, add_g);
        end
        @(negedge clock);
        // Cycle 2: A=fffffffe, {Q0,q1}=01 -> add 3
        checks++;
        if (add_x !== 32'hFFFFFFFE || add_y !== 32'h3 || add_cin !== 1'b0 ||
            add_p !== 32'hFFFFFFFF || add_g !== 32'h2) begin
            errors++;
            $display("FAIL run_cycle2: x=%h y=%h cin=%b p=%h g=%h want fffffffe/3/0/ffffffff/2",
                     add_x, add_y, add_cin, add_p, add_g);
        end
        repeat (40) @(negedge clock);
    endtask

    task automatic test_products();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [31:0] vr [5];
        logic        ve [5];
        int n, f, l;
        logic [31:0] r;
        logic e;
        va[0] = 32'd3;        vb[0] = 32'd5;        vr[0] = 32'h0000000F; ve[0] = 1'b0;
        va[1] = -32'sd7;      vb[1] = 32'd6;        vr[1] = 32'hFFFFFFD6; ve[1] = 1'b0;
        va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; vr[2] = 32'h80000000; ve[2] = OVF_ON;
        va[3] = 32'h00010000; vb[3] = 32'h00010000; vr[3] = 32'h00000000; ve[3] = OVF_ON;
        va[4] = 32'h80000000; vb[4] = 32'h80000000; vr[4] = 32'h00000000; ve[4] = OVF_ON;
        for (int i = 0; i < 5; i++) begin
            drive_window(va[i], vb[i], -1, 1'b0, 32'h0, 32'h0, 36, n, f, l, r, e);
            checks++;
            if (n !== 1 || f !== 33) begin
                errors++;
                $display("FAIL prod%0d_rdy: pulses=%0d at=%0d want 1 at 33", i, n, f);
            end
            checks++;
            if (r !== vr[i] || e !== ve[i]) begin
                errors++;
                $display("FAIL prod%0d_value: res=%h exc=%b want %h/%b", i, r, e, vr[i], ve[i]);
            end
        end
        checks++;
        if (data_result !== vr[4] || add_x !== 32'h0 || add_p !== 32'h0) begin
            errors++;
            $display("FAIL hold_idle: res=%h x=%h p=%h want %h/0/0",
                     data_result, add_x, add_p, vr[4]);
        end
    endtask

    task automatic test_abort();
        int n, f, l;
        logic [31:0] r;
        logic e;
        drive_window(32'd3, 32'd5, 10, 1'b0, 32'd4, 32'd4, 50, n, f, l, r, e);
        checks++;
        if (n !== 1 || f !== 43) begin
            errors++;
            $display("FAIL abort_rdy: pulses=%0d at=%0d want 1 at 43", n, f);
        end
        checks++;
        if (r !== 32'h10 || e !== 1'b0) begin
            errors++;
            $display("FAIL abort_value: res=%h exc=%b want 00000010/0", r, e);
        end
    endtask

    task automatic test_back_to_back();
        int n, f, l;
        logic [31:0] r;
        logic e;
        drive_window(32'd3, 32'd5, 33, 1'b0, -32'sd7, 32'd6, 70, n, f, l, r, e);
        checks++;
        if (n !== 2 || f !== 33 || l !== 66) begin
            errors++;
            $display("FAIL b2b_rdy: pulses=%0d first=%0d last=%0d want 2/33/66", n, f, l);
        end
        checks++;
        if (r !== 32'hF || data_result !== 32'hFFFFFFD6) begin
            errors++;
            $display("FAIL b2b_value: first=%h second=%h want 0000000f/ffffffd6", r, data_result);
        end
    endtask

    task automatic test_reset_mid();
        int n, f, l;
        logic [31:0] r;
        logic e;
        drive_window(32'd3, 32'd5, 15, 1'b1, 32'h0, 32'h0, 50, n, f, l, r, e);
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL reset_mid_rdy: pulses=%0d want 0", n);
        end
        checks++;
        if (data_result !== 32'h0 || data_exception !== 1'b0 || add_x !== 32'h0 ||
            add_y !== 32'h0 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: res=%h exc=%b x=%h y=%h cin=%b want all 0",
                     data_result, data_exception, add_x, add_y, add_cin);
        end
        drive_window(32'd2, 32'd2, -1, 1'b0, 32'h0, 32'h0, 36, n, f, l, r, e);
        checks++;
        if (n !== 1 || f !== 33 || r !== 32'h4) begin
            errors++;
            $display("FAIL after_reset: pulses=%0d at=%0d res=%h want 1/33/00000004", n, f, r);
        end
    endtask

    initial begin
        reset = 1'b1; ctrl = 1'b0; opa = '0; opb = '0;
        test_reset();
        test_adder_drive();
        test_products();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
